// File: rtl/can_pkg.sv
// Shared CAN bit-stream definitions used by the TX stuffer and the RX de-stuffer.
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_STUFF
  } state_t;

  localparam int   CAN_STUFF_LEN = 5;
  localparam logic CAN_RECESSIVE = 1'b1;

endpackage

// File: rtl/can_bit_stuffer.sv
// TX-side CAN bit stuffer: emits one bit per bit_tick and inserts a complementary
// stuff bit after STUFF_LEN identical bits while din_stuff qualifies the stream.
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int   STUFF_LEN = CAN_STUFF_LEN,
  parameter logic RECESSIVE = CAN_RECESSIVE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_tick,
  input  logic frame_start,
  input  logic din,
  input  logic din_valid,
  input  logic din_stuff,
  input  logic din_last,
  output logic din_ready,
  output logic tx_bit,
  output logic tx_is_stuff,
  output logic underrun,
  output logic busy
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;
  logic             last_bit;
  logic             last_flag;  // bit that forced the stuff closed the frame

  assign din_ready = (state == ST_DATA) & bit_tick & ~frame_start;
  assign busy      = (state != ST_IDLE);

  // Run length after accepting din; saturates so long unstuffed runs never wrap.
  always_comb begin
    run_nxt = CNT_W'(1);
    if (din == last_bit) begin
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments and cleared by an
  // asynchronous reset, so every flop here returns to its idle value instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_bit      <= RECESSIVE;
      tx_is_stuff <= 1'b0;
      underrun    <= 1'b0;
      run_cnt     <= '0;
      last_bit    <= RECESSIVE;
      last_flag   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (frame_start) begin
        run_cnt   <= '0;
        last_bit  <= RECESSIVE;
        last_flag <= 1'b0;
        state     <= ST_DATA;
      end else if (bit_tick) begin
        unique case (state)
          ST_IDLE: begin
            tx_bit      <= RECESSIVE;
            tx_is_stuff <= 1'b0;
          end
          ST_DATA: begin
            tx_is_stuff <= 1'b0;
            if (din_valid) begin
              tx_bit   <= din;
              run_cnt  <= run_nxt;
              last_bit <= din;
              if (run_nxt == RUN_MAX && din_stuff) begin
                state     <= ST_STUFF;
                last_flag <= din_last;
              end else if (din_last) begin
                state <= ST_IDLE;
              end
            end else begin
              tx_bit   <= RECESSIVE;
              underrun <= 1'b1;
              run_cnt  <= '0;
            end
          end
          ST_STUFF: begin
            tx_bit      <= ~last_bit;
            tx_is_stuff <= 1'b1;
            last_bit    <= ~last_bit;
            run_cnt     <= CNT_W'(1);
            last_flag   <= 1'b0;
            state       <= last_flag ? ST_IDLE : ST_DATA;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed bench for can_bit_stuffer: each scenario is a table of per-tick inputs
// and hand-computed outputs.
module tb_can_bit_stuffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_tick = 1'b0;
  logic frame_start = 1'b0;
  logic din = 1'b1;
  logic din_valid = 1'b0;
  logic din_stuff = 1'b0;
  logic din_last = 1'b0;
  logic din_ready, tx_bit, tx_is_stuff, underrun, busy;

  int n_checks = 0;
  int n_fail = 0;

  // Row layout: {fs, din, valid, stuff, last} _ {ready, tx, is_stuff, underrun, busy}
  typedef logic [9:0] row_t;

  can_bit_stuffer dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .frame_start(frame_start),
    .din(din), .din_valid(din_valid), .din_stuff(din_stuff), .din_last(din_last),
    .din_ready(din_ready), .tx_bit(tx_bit), .tx_is_stuff(tx_is_stuff),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One tick cycle followed by one idle cycle; samples outputs after each edge.
  task automatic step(input row_t r, output logic rdy, output logic tx, output logic st,
                      output logic ur, output logic bz, output logic tx_h, output logic ur_h);
    @(negedge clk);
    frame_start = r[9]; din = r[8]; din_valid = r[7]; din_stuff = r[6]; din_last = r[5];
    bit_tick = 1'b1;
    #1 rdy = din_ready;
    @(posedge clk);
    #1 tx = tx_bit; st = tx_is_stuff; ur = underrun; bz = busy;
    @(negedge clk);
    bit_tick = 1'b0; frame_start = 1'b0; din_valid = 1'b0;
    @(posedge clk);
    #1 tx_h = tx_bit; ur_h = underrun;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_bit, tx_is_stuff, underrun, busy, din_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_state: got tx/st/ur/busy/rdy=%b want 10000",
               {tx_bit, tx_is_stuff, underrun, busy, din_ready});
    end
    @(negedge clk);
    bit_tick = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_stuff_zeros();
    row_t rows [7] = '{10'b00110_10001, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                       10'b00110_10001, 10'b01110_01101, 10'b01111_11000};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL zeros_busy_after_start: got %b want 1", busy);
    end
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL zeros tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
  endtask

  task automatic test_stuff_ones();
    row_t rows [12] = '{10'b01110_11001, 10'b01110_11001, 10'b01110_11001, 10'b01110_11001,
                        10'b01110_11001, 10'b01110_00101, 10'b01110_11001, 10'b01110_11001,
                        10'b01110_11001, 10'b01110_11001, 10'b01111_11001, 10'b00000_00100};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL ones tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
  endtask

  task automatic test_crc_tail();
    row_t rows [14] = '{10'b00110_10001, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                        10'b00110_10001, 10'b01100_01101, 10'b01100_11001, 10'b01100_11001,
                        10'b01100_11001, 10'b01100_11001, 10'b01100_11001, 10'b01100_11001,
                        10'b01101_11000, 10'b01100_01000};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL crc_tail tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
  endtask

  task automatic test_last_stuff();
    row_t rows [8] = '{10'b01110_11001, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                       10'b00110_10001, 10'b00111_10001, 10'b00000_01100, 10'b01110_01000};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL last_stuff tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
  endtask

  task automatic test_underrun();
    row_t rows [9] = '{10'b00110_10001, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                       10'b00000_11011, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                       10'b00111_10000};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL underrun tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
  endtask

  task automatic test_restart_and_reset();
    row_t rows [9] = '{10'b00110_10001, 10'b00110_10001, 10'b00110_10001, 10'b10110_00001,
                       10'b00110_10001, 10'b00110_10001, 10'b00110_10001, 10'b00110_10001,
                       10'b00110_10001};
    logic rdy, tx, st, ur, bz, tx_h, ur_h;
    start_frame();
    foreach (rows[i]) begin
      step(rows[i], rdy, tx, st, ur, bz, tx_h, ur_h);
      n_checks++;
      if ({rdy, tx, st, ur, bz, tx_h, ur_h} !== {rows[i][4:0], rows[i][3], 1'b0}) begin
        n_fail++;
        $display("FAIL restart tick %0d: got rdy/tx/st/ur/busy/hold_tx/hold_ur=%b want %b",
                 i, {rdy, tx, st, ur, bz, tx_h, ur_h}, {rows[i][4:0], rows[i][3], 1'b0});
      end
    end
    // Now parked in STUFF with tx_bit=0; reset lands between clock edges.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_bit, tx_is_stuff, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset_in_stuff: got tx/st/busy=%b want 100",
               {tx_bit, tx_is_stuff, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stuff_zeros();
    test_stuff_ones();
    test_crc_tail();
    test_last_stuff();
    test_underrun();
    test_restart_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
